// File: rtl/mul2_share_ctrl.sv
// Round-robin sharing of one 2-bit product/carry datapath between two requesters.
// Latency: 2 edges from accept to rsp_valid; the response holds until rsp_ready and req_ready stays low while busy.

module mul2_share_dp (
    input  logic [1:0] i_x,
    input  logic [1:0] i_y,
    input  logic       i_z,
    output logic [1:0] o_u,
    output logic [1:0] o_w
);
    assign o_u = {(i_x[1] & i_y[0]) ^ (i_x[0] & i_y[1]), i_x[0] & i_y[0]};
    assign o_w = {i_y[0] | i_z, i_y[1] ^ (i_y[0] & i_z)};
endmodule

module mul2_share_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_x,
    input  logic [3:0]       req_y,
    input  logic [1:0]       req_z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [1:0]       rsp_u,
    output logic [1:0]       rsp_w,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             r_op_id;
    logic [1:0]       r_op_x;
    logic [1:0]       r_op_y;
    logic             r_op_z;
    logic             r_rsp_vld;
    logic             r_rsp_id;
    logic [1:0]       r_rsp_u;
    logic [1:0]       r_rsp_w;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_gnt;
    logic             w_accept;
    logic             w_rsp_hs;
    logic             w_load_rsp;
    logic [1:0]       w_sel_x;
    logic [1:0]       w_sel_y;
    logic             w_sel_z;
    logic [1:0]       w_dp_u;
    logic [1:0]       w_dp_w;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_gnt = req_valid[1];
        if (&req_valid) begin
            w_gnt = ~r_last;
        end
    end

    assign w_sel_x = w_gnt ? req_x[3:2] : req_x[1:0];
    assign w_sel_y = w_gnt ? req_y[3:2] : req_y[1:0];
    assign w_sel_z = w_gnt ? req_z[1]   : req_z[0];

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        w_accept    = 1'b0;
        w_rsp_hs    = 1'b0;
        w_load_rsp  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_accept    = 1'b1;
                    req_ready   = w_gnt ? 2'b10 : 2'b01;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_load_rsp  = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_op_id <= 1'b0;
            r_op_x  <= 2'b00;
            r_op_y  <= 2'b00;
            r_op_z  <= 1'b0;
        end else if (w_accept) begin
            r_last  <= w_gnt;
            r_op_id <= w_gnt;
            r_op_x  <= w_sel_x;
            r_op_y  <= w_sel_y;
            r_op_z  <= w_sel_z;
        end
    end

    // The datapath only ever sees the latched operands, never live request lines.
    mul2_share_dp u_dp (
        .i_x (r_op_x),
        .i_y (r_op_y),
        .i_z (r_op_z),
        .o_u (w_dp_u),
        .o_w (w_dp_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_vld <= 1'b0;
            r_rsp_id  <= 1'b0;
            r_rsp_u   <= 2'b00;
            r_rsp_w   <= 2'b00;
        end else if (w_load_rsp) begin
            r_rsp_vld <= 1'b1;
            r_rsp_id  <= r_op_id;
            r_rsp_u   <= w_dp_u;
            r_rsp_w   <= w_dp_w;
        end else if (w_rsp_hs) begin
            r_rsp_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_rsp_hs) begin
            if (r_rsp_id) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end else begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
        end
    end

    assign rsp_valid = r_rsp_vld;
    assign rsp_id    = r_rsp_id;
    assign rsp_u     = r_rsp_u;
    assign rsp_w     = r_rsp_w;
    assign busy      = (r_state != IDLE);
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;
endmodule

// File: tb/tb_mul2_share_ctrl.sv
// Directed bench for mul2_share_ctrl with a response scoreboard; a second instance
// with 2-bit counters runs in lockstep to exercise counter wrap.
module tb_mul2_share_ctrl;
    typedef struct packed {
        logic       id;
        logic [1:0] u;
        logic [1:0] w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [3:0] req_x;
    logic [3:0] req_y;
    logic [1:0] req_z;
    logic       rsp_ready;
    logic [1:0] req_ready;
    logic       rsp_valid;
    logic       rsp_id;
    logic [1:0] rsp_u;
    logic [1:0] rsp_w;
    logic       busy;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] req_ready_w;
    logic       rsp_valid_w;
    logic       rsp_id_w;
    logic [1:0] rsp_u_w;
    logic [1:0] rsp_w_w;
    logic       busy_w;
    logic [1:0] cnt0_w;
    logic [1:0] cnt1_w;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    int   exp_cnt0 = 0;
    int   exp_cnt1 = 0;
    bit   have_acc = 0;
    bit   spacing_on = 0;
    bit   rand_rdy = 0;
    logic exp_last = 1'b1;
    logic [1:0] acc_vec;
    exp_t q[$];

    always #5 clk = ~clk;

    mul2_share_ctrl #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_u(rsp_u), .rsp_w(rsp_w),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    mul2_share_ctrl #(.CNT_W(2)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .rsp_valid(rsp_valid_w),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id_w), .rsp_u(rsp_u_w), .rsp_w(rsp_w_w),
        .busy(busy_w), .cnt0(cnt0_w), .cnt1(cnt1_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic product mod 4 and the carry-side formula.
    function automatic exp_t model(input logic id, input logic [1:0] x, input logic [1:0] y, input logic z);
        exp_t e;
        int   p;
        p    = int'(x) * int'(y);
        e.id = id;
        e.u  = 2'(p % 4);
        e.w  = {y[0] | z, y[1] ^ (y[0] & z)};
        return e;
    endfunction

    task automatic set_op(input int r, input logic [1:0] x, input logic [1:0] y, input logic z);
        req_x[r*2 +: 2] = x;
        req_y[r*2 +: 2] = y;
        req_z[r]        = z;
    endtask

    // One clock: observe handshakes at the falling edge, then advance past the rising edge.
    task automatic step();
        logic g;
        int   ii;
        exp_t e;
        @(negedge clk);
        acc_vec = 2'b00;
        if (rst_n) begin
            chk("ready_subset_of_valid", 32'(req_ready & ~req_valid), 32'(0));
            acc_vec = req_valid & req_ready;
            if (acc_vec != 2'b00) begin
                g = (&req_valid) ? ~exp_last : req_valid[1];
                chk("grant", 32'(acc_vec), g ? 32'(2) : 32'(1));
                exp_last = g;
                if (spacing_on && have_acc) chk("accept_spacing", 32'(cyc - last_acc_cyc), 32'(3));
                last_acc_cyc = cyc;
                have_acc     = 1'b1;
                ii = acc_vec[1] ? 1 : 0;
                q.push_back(model(acc_vec[1], req_x[ii*2 +: 2], req_y[ii*2 +: 2], req_z[ii]));
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(q.size() != 0), 32'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_u", 32'(rsp_u), 32'(e.u));
                    chk("rsp_w", 32'(rsp_w), 32'(e.w));
                    if (e.id) exp_cnt1++;
                    else exp_cnt0++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            chk("cnt0", 32'(cnt0), 32'(exp_cnt0 % 256));
            chk("cnt1", 32'(cnt1), 32'(exp_cnt1 % 256));
            chk("cnt0_wrap", 32'(cnt0_w), 32'(exp_cnt0 % 4));
            chk("cnt1_wrap", 32'(cnt1_w), 32'(exp_cnt1 % 4));
        end
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int r, input logic [1:0] x, input logic [1:0] y, input logic z);
        bit ok;
        ok = 1'b0;
        set_op(r, x, y, z);
        req_valid[r] = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = acc_vec[r];
        end
        req_valid[r] = 1'b0;
        chk("accept_within_bound", 32'(ok), 32'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) step();
        chk("drain_empty", 32'(q.size()), 32'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            req_valid = 2'($urandom_range(0, 3));
            req_x     = 4'($urandom_range(0, 15));
            req_y     = 4'($urandom_range(0, 15));
            req_z     = 2'($urandom_range(0, 3));
            rsp_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_hold_busy", 32'(busy), 32'(0));
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        q.delete();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        exp_last = 1'b1;
        have_acc = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_id", 32'(rsp_id), 32'(0));
        chk("rst_rsp_u", 32'(rsp_u), 32'(0));
        chk("rst_rsp_w", 32'(rsp_w), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cnt0", 32'(cnt0), 32'(0));
        chk("rst_cnt1", 32'(cnt1), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         ok;
        exp_t       e;
        logic [1:0] hold_u;
        logic [1:0] hold_w;
        logic       hold_id;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_x     = 4'h0;
        req_y     = 4'h0;
        req_z     = 2'b00;
        rsp_ready = 1'b0;

        do_reset();

        // Reset asserted while a result is waiting in RESP.
        rsp_ready = 1'b0;
        send(0, 2'd1, 2'd2, 1'b1);
        step();
        chk("mid_rsp_valid_before", 32'(rsp_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_rsp_u", 32'(rsp_u), 32'(0));
        chk("mid_rst_cnt0", 32'(cnt0), 32'(exp_cnt0));
        q.delete();
        exp_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_post_busy", 32'(busy), 32'(0));
        chk("mid_post_cnt0", 32'(cnt0), 32'(exp_cnt0));

        // Tie and rotation: both valid, back-to-back accepts.
        rsp_ready  = 1'b1;
        spacing_on = 1'b1;
        have_acc   = 1'b0;
        set_op(0, 2'd1, 2'd3, 1'b0);
        set_op(1, 2'd2, 2'd1, 1'b1);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                step();
                ok = (acc_vec != 2'b00);
            end
            chk("rot_accept", 32'(ok), 32'(1));
            chk("rot_order", 32'(acc_vec), (k % 2) ? 32'(2) : 32'(1));
            if (acc_vec[0]) set_op(0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        req_valid  = 2'b00;
        spacing_on = 1'b0;
        drain();

        // Single request timing.
        rsp_ready = 1'b1;
        send(0, 2'd3, 2'd3, 1'b0);
        chk("single_exec_busy", 32'(busy), 32'(1));
        chk("single_exec_rsp_valid", 32'(rsp_valid), 32'(0));
        step();
        e = model(1'b0, 2'd3, 2'd3, 1'b0);
        chk("single_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("single_rsp_id", 32'(rsp_id), 32'(e.id));
        chk("single_rsp_u", 32'(rsp_u), 32'(e.u));
        chk("single_rsp_w", 32'(rsp_w), 32'(e.w));
        step();
        chk("single_idle", 32'(busy), 32'(0));
        drain();

        // Backpressure with a competing request waiting.
        rsp_ready = 1'b0;
        send(1, 2'd0, 2'd2, 1'b1);
        step();
        hold_u  = rsp_u;
        hold_w  = rsp_w;
        hold_id = rsp_id;
        set_op(0, 2'd2, 2'd3, 1'b1);
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("bp_stable", {27'd0, hold_id, hold_u, hold_w}, {27'd0, rsp_id, rsp_u, rsp_w});
            chk("bp_req_ready", 32'(req_ready), 32'(0));
            chk("bp_busy", 32'(busy), 32'(1));
        end
        rsp_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = acc_vec[0];
        end
        chk("bp_follow_accept", 32'(ok), 32'(1));
        req_valid = 2'b00;
        drain();

        // Counter wrap on the 2-bit instance.
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        drain();
        chk("wrap_cnt1_narrow", 32'(cnt1_w), 32'(exp_cnt1 % 4));
        chk("wrap_cnt0_narrow", 32'(cnt0_w), 32'(exp_cnt0 % 4));
        chk("wrap_cnt1_wide", 32'(cnt1), 32'(exp_cnt1));

        // Exhaustive operands from each requester under random response backpressure.
        rand_rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 32; v++) begin
                send(r, 2'(v >> 3), 2'((v >> 1) & 3), 1'(v & 1));
            end
        end
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
